// File: rtl/splitting_4kb_ctrl.sv
// -----------------------------------------------------------------------------
// splitting_4kb_ctrl
// Sequences one AXI4 address channel (AW or AR) through 4KB-boundary splitting.
// A burst accepted from the upstream port is held and re-issued downstream as
// one sub-burst (no crossing) or two sub-bursts (crossing). Each accepted burst
// pushes {ID, split} into a small first-word-fall-through info FIFO, which the
// response path uses to merge B/R responses.
//
// Ports
//   ACLK_i, ARESET_i             clock, async active-high reset
//   s_Ax{ID,ADDR,LEN,SIZE}_i     upstream burst fields
//   s_AxVALID_i / s_AxREADY_o    upstream handshake
//   m_Ax{ID,ADDR,LEN,SIZE}_o     downstream sub-burst fields
//   m_AxVALID_o / m_AxREADY_i    downstream handshake
//   m_split_first_o              current sub-burst is the first half of a split
//   info_ID_o, info_split_o      info FIFO head
//   info_valid_o / info_ready_i  info FIFO handshake (pop)
// -----------------------------------------------------------------------------
module splitting_4kb_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int SIZE_WIDTH = 3,
  parameter int ID_WIDTH   = 4,
  parameter int INFO_DEPTH = 4
) (
  input  logic                  ACLK_i,
  input  logic                  ARESET_i,
  input  logic [ID_WIDTH-1:0]   s_AxID_i,
  input  logic [ADDR_WIDTH-1:0] s_AxADDR_i,
  input  logic [LEN_WIDTH-1:0]  s_AxLEN_i,
  input  logic [SIZE_WIDTH-1:0] s_AxSIZE_i,
  input  logic                  s_AxVALID_i,
  output logic                  s_AxREADY_o,
  output logic [ID_WIDTH-1:0]   m_AxID_o,
  output logic [ADDR_WIDTH-1:0] m_AxADDR_o,
  output logic [LEN_WIDTH-1:0]  m_AxLEN_o,
  output logic [SIZE_WIDTH-1:0] m_AxSIZE_o,
  output logic                  m_AxVALID_o,
  input  logic                  m_AxREADY_i,
  output logic                  m_split_first_o,
  output logic [ID_WIDTH-1:0]   info_ID_o,
  output logic                  info_split_o,
  output logic                  info_valid_o,
  input  logic                  info_ready_i
);

  // Width that holds (LEN+1) << SIZE for any field value.
  localparam int TW = LEN_WIDTH + (1 << SIZE_WIDTH);
  localparam int PW = $clog2(INFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_t;

  // End offset within the 4KB page, 13 bits: bit 12 set means the burst
  // reaches or passes the next page boundary.
  function automatic logic [12:0] calc_end(input logic [11:0]           a,
                                           input logic [LEN_WIDTH-1:0]  l,
                                           input logic [SIZE_WIDTH-1:0] s);
    return 13'(TW'(a) + ((TW'(l) + TW'(1)) << s));
  endfunction

  // Ending exactly on the boundary still fits in the page.
  function automatic logic is_cross(input logic [12:0] e);
    return e[12] & (e[11:0] != 12'd0);
  endfunction

  state_t                r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [SIZE_WIDTH-1:0] r_size;

  logic [ID_WIDTH-1:0]   r_fifo_id [INFO_DEPTH];
  logic [INFO_DEPTH-1:0] r_fifo_split;
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [PW:0]           r_count;

  logic [12:0] w_end;
  logic        w_cross, w_in_cross, w_final, w_accept, w_pop, w_full, w_empty;
  logic [11:0] w_rem;

  assign w_end      = calc_end(r_addr[11:0], r_len, r_size);
  assign w_cross    = is_cross(w_end);
  // Beats that land in the next page.
  assign w_rem      = w_end[11:0] >> r_size;
  assign w_in_cross = is_cross(calc_end(s_AxADDR_i[11:0], s_AxLEN_i, s_AxSIZE_i));

  assign w_full  = (r_count == (PW+1)'(INFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & info_ready_i;

  // The last sub-burst of the held burst; its handshake frees the hold
  // register so a new burst can be loaded in the same cycle.
  assign w_final     = ((r_state == ISSUE1) & ~w_cross) | (r_state == ISSUE2);
  assign s_AxREADY_o = ~w_full & ((r_state == IDLE) | (w_final & m_AxREADY_i));
  assign w_accept    = s_AxVALID_i & s_AxREADY_o;

  assign m_AxID_o     = r_id;
  assign m_AxSIZE_o   = r_size;
  assign info_valid_o = ~w_empty;
  assign info_ID_o    = r_fifo_id[r_rptr];
  assign info_split_o = r_fifo_split[r_rptr];

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    m_AxVALID_o     = 1'b0;
    m_AxADDR_o      = r_addr;
    m_AxLEN_o       = r_len;
    m_split_first_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = ISSUE1;
      end
      ISSUE1: begin
        m_AxVALID_o     = 1'b1;
        m_split_first_o = w_cross;
        if (w_cross) m_AxLEN_o = r_len - LEN_WIDTH'(w_rem);
        if (m_AxREADY_i) begin
          if (w_cross)       w_state_nxt = ISSUE2;
          else if (w_accept) w_state_nxt = ISSUE1;
          else               w_state_nxt = IDLE;
        end
      end
      ISSUE2: begin
        m_AxVALID_o = 1'b1;
        m_AxADDR_o  = {r_addr[ADDR_WIDTH-1:12] + (ADDR_WIDTH-12)'(1), 12'h000};
        m_AxLEN_o   = LEN_WIDTH'(w_rem - 12'd1);
        if (m_AxREADY_i) w_state_nxt = w_accept ? ISSUE1 : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Held burst
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      r_id   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
    end else if (w_accept) begin
      r_id   <= s_AxID_i;
      r_addr <= s_AxADDR_i;
      r_len  <= s_AxLEN_i;
      r_size <= s_AxSIZE_i;
    end
  end

  // Info FIFO control
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + PW'(1);
      if (w_pop)    r_rptr <= r_rptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Info FIFO storage; entries are only read while the count covers them.
  always_ff @(posedge ACLK_i) begin
    if (w_accept) begin
      r_fifo_id[r_wptr]    <= s_AxID_i;
      r_fifo_split[r_wptr] <= w_in_cross;
    end
  end

endmodule

// File: tb/tb_splitting_4kb_ctrl.sv
module tb_splitting_4kb_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET_i = 1'b1;
  logic [3:0]  s_AxID_i = '0;
  logic [31:0] s_AxADDR_i = '0;
  logic [7:0]  s_AxLEN_i = '0;
  logic [2:0]  s_AxSIZE_i = '0;
  logic        s_AxVALID_i = 1'b0;
  logic        s_AxREADY_o;
  logic [3:0]  m_AxID_o;
  logic [31:0] m_AxADDR_o;
  logic [7:0]  m_AxLEN_o;
  logic [2:0]  m_AxSIZE_o;
  logic        m_AxVALID_o;
  logic        m_AxREADY_i = 1'b0;
  logic        m_split_first_o;
  logic [3:0]  info_ID_o;
  logic        info_split_o;
  logic        info_valid_o;
  logic        info_ready_i = 1'b0;

  always #5 ACLK = ~ACLK;

  splitting_4kb_ctrl dut (
    .ACLK_i(ACLK), .ARESET_i(ARESET_i),
    .s_AxID_i(s_AxID_i), .s_AxADDR_i(s_AxADDR_i), .s_AxLEN_i(s_AxLEN_i),
    .s_AxSIZE_i(s_AxSIZE_i), .s_AxVALID_i(s_AxVALID_i), .s_AxREADY_o(s_AxREADY_o),
    .m_AxID_o(m_AxID_o), .m_AxADDR_o(m_AxADDR_o), .m_AxLEN_o(m_AxLEN_o),
    .m_AxSIZE_o(m_AxSIZE_o), .m_AxVALID_o(m_AxVALID_o), .m_AxREADY_i(m_AxREADY_i),
    .m_split_first_o(m_split_first_o),
    .info_ID_o(info_ID_o), .info_split_o(info_split_o),
    .info_valid_o(info_valid_o), .info_ready_i(info_ready_i)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        split;
  } beat_t;

  typedef struct packed {
    logic [3:0] id;
    logic       split;
  } info_t;

  beat_t exp_beats[$], obs_beats[$];
  info_t exp_info[$],  obs_info[$];
  int n_cmp = 0;
  int n_err = 0;

  // Record every downstream handshake and info pop; inputs only change on
  // the falling edge, so values seen 1ns later hold through the rising edge.
  always @(negedge ACLK) begin
    #1;
    if (!ARESET_i && m_AxVALID_o && m_AxREADY_i)
      obs_beats.push_back('{m_AxID_o, m_AxADDR_o, m_AxLEN_o, m_AxSIZE_o, m_split_first_o});
    if (!ARESET_i && info_valid_o && info_ready_i)
      obs_info.push_back('{info_ID_o, info_split_o});
  end

  // Reference: bytes left in the page versus bytes in the burst.
  function automatic void model_push(input logic [3:0] id, input logic [31:0] a,
                                     input logic [7:0] l, input logic [2:0] s);
    int total, room, b1;
    logic [31:0] a2;
    total = (int'(l) + 1) << s;
    room  = 4096 - int'(a[11:0]);
    if (total > room) begin
      b1 = room >> s;
      a2 = {a[31:12] + 20'd1, 12'h000};
      exp_beats.push_back('{id, a, 8'(b1 - 1), s, 1'b1});
      exp_beats.push_back('{id, a2, 8'(int'(l) - b1), s, 1'b0});
      exp_info.push_back('{id, 1'b1});
    end else begin
      exp_beats.push_back('{id, a, l, s, 1'b0});
      exp_info.push_back('{id, 1'b0});
    end
  endfunction

  // Present a burst until accepted (called on a falling edge, returns on one).
  task automatic send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                      input logic [2:0] s, output int waited);
    s_AxID_i = id; s_AxADDR_i = a; s_AxLEN_i = l; s_AxSIZE_i = s;
    s_AxVALID_i = 1'b1;
    waited = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (s_AxREADY_o) begin
        waited = i;
        model_push(id, a, l, s);
        @(negedge ACLK);
        break;
      end
      @(negedge ACLK);
    end
    s_AxVALID_i = 1'b0;
    if (waited < 0) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout id=%0d: s_AxREADY_o never rose within 40 cycles", id);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      #2;
      if (obs_beats.size() >= exp_beats.size() && obs_info.size() >= exp_info.size()) break;
      @(negedge ACLK);
    end
    repeat (3) @(negedge ACLK);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge ACLK);
    #1;
    n_cmp++;
    if ({m_AxVALID_o, m_split_first_o, info_valid_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_hold: valid/split_first/info_valid got %b want 000",
               {m_AxVALID_o, m_split_first_o, info_valid_o});
    end
    @(negedge ACLK);
    ARESET_i = 1'b0;
    #1;
    n_cmp++;
    if ({s_AxREADY_o, m_AxVALID_o, info_valid_o} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: ready/valid/info_valid got %b want 100",
               {s_AxREADY_o, m_AxVALID_o, info_valid_o});
    end
    @(negedge ACLK);
  endtask

  task automatic test_single(input string name, input logic [3:0] id, input logic [31:0] a,
                             input logic [7:0] l, input logic [2:0] s);
    int w;
    beat_t e, o;
    info_t ei, oi;
    @(negedge ACLK);
    m_AxREADY_i = 1'b1; info_ready_i = 1'b1;
    send(id, a, l, s, w);
    wait_drain();
    n_cmp++;
    if (obs_beats.size() !== exp_beats.size() || obs_info.size() !== exp_info.size()) begin
      n_err++;
      $display("FAIL %s count: beats %0d info %0d, want beats %0d info %0d", name,
               obs_beats.size(), obs_info.size(), exp_beats.size(), exp_info.size());
    end
    while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
      e = exp_beats.pop_front(); o = obs_beats.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s beat: got id=%h addr=%h len=%0d size=%0d sf=%b want id=%h addr=%h len=%0d size=%0d sf=%b",
                 name, o.id, o.addr, o.len, o.size, o.split, e.id, e.addr, e.len, e.size, e.split);
      end
    end
    while (exp_info.size() > 0 && obs_info.size() > 0) begin
      ei = exp_info.pop_front(); oi = obs_info.pop_front();
      n_cmp++;
      if (oi !== ei) begin
        n_err++;
        $display("FAIL %s info: got id=%h split=%b want id=%h split=%b", name, oi.id, oi.split, ei.id, ei.split);
      end
    end
    exp_beats.delete(); obs_beats.delete(); exp_info.delete(); obs_info.delete();
  endtask

  task automatic test_backpressure();
    int w;
    beat_t cur;
    beat_t ph1 = '{4'h4, 32'h0000_0FF0, 8'd3, 3'd2, 1'b1};
    beat_t ph2 = '{4'h4, 32'h0000_1000, 8'd3, 3'd2, 1'b0};
    @(negedge ACLK);
    m_AxREADY_i = 1'b0; info_ready_i = 1'b1;
    send(4'h4, 32'h0000_0FF0, 8'd7, 3'd2, w);
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 5; c++) begin
        #1;
        cur = '{m_AxID_o, m_AxADDR_o, m_AxLEN_o, m_AxSIZE_o, m_split_first_o};
        n_cmp++;
        if (cur !== (ph == 0 ? ph1 : ph2) || {m_AxVALID_o, s_AxREADY_o} !== 2'b10) begin
          n_err++;
          $display("FAIL backpressure_hold ph%0d c%0d: fields=%h valid/ready=%b want %h 10",
                   ph, c, cur, {m_AxVALID_o, s_AxREADY_o}, (ph == 0 ? ph1 : ph2));
        end
        @(negedge ACLK);
      end
      m_AxREADY_i = 1'b1;
      #1;
      n_cmp++;
      if (s_AxREADY_o !== (ph == 1)) begin
        n_err++;
        $display("FAIL backpressure_ready ph%0d: s_AxREADY_o=%b want %b", ph, s_AxREADY_o, (ph == 1));
      end
      @(negedge ACLK);
      m_AxREADY_i = 1'b0;
    end
    m_AxREADY_i = 1'b1;
    wait_drain();
    n_cmp++;
    if (obs_beats.size() !== 2 || exp_beats.size() !== 2) begin
      n_err++;
      $display("FAIL backpressure_count: beats %0d want %0d", obs_beats.size(), exp_beats.size());
    end
    while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
      n_cmp++;
      if (obs_beats[0] !== exp_beats[0]) begin
        n_err++;
        $display("FAIL backpressure_beat: got %h want %h", obs_beats[0], exp_beats[0]);
      end
      void'(obs_beats.pop_front()); void'(exp_beats.pop_front());
    end
    exp_beats.delete(); obs_beats.delete(); exp_info.delete(); obs_info.delete();
  endtask

  task automatic test_fifo_full();
    int w;
    @(negedge ACLK);
    m_AxREADY_i = 1'b1; info_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) send(4'(5 + k), 32'(k + 1) << 8, 8'd0, 3'd2, w);
    s_AxID_i = 4'h9; s_AxADDR_i = 32'h0000_0500; s_AxLEN_i = 8'd0; s_AxSIZE_i = 3'd2;
    s_AxVALID_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (s_AxREADY_o !== 1'b0) begin
        n_err++; $display("FAIL fifo_full_block c%0d: s_AxREADY_o=%b want 0", c, s_AxREADY_o);
      end
      @(negedge ACLK);
    end
    info_ready_i = 1'b1;
    #1;
    n_cmp++;
    if ({s_AxREADY_o, info_valid_o, info_ID_o} !== {1'b0, 1'b1, 4'h5}) begin
      n_err++;
      $display("FAIL fifo_full_pop_cycle: ready/info_valid/head=%b/%b/%h want 0/1/5",
               s_AxREADY_o, info_valid_o, info_ID_o);
    end
    @(negedge ACLK);
    info_ready_i = 1'b0;
    #1;
    n_cmp++;
    if (s_AxREADY_o !== 1'b1) begin
      n_err++; $display("FAIL fifo_full_resume: s_AxREADY_o=%b want 1", s_AxREADY_o);
    end else model_push(4'h9, 32'h0000_0500, 8'd0, 3'd2);
    @(negedge ACLK);
    s_AxVALID_i = 1'b0;
    info_ready_i = 1'b1;
    wait_drain();
    n_cmp++;
    if (obs_info.size() !== 5 || exp_info.size() !== 5) begin
      n_err++; $display("FAIL fifo_full_count: info pops %0d want 5", obs_info.size());
    end
    while (exp_info.size() > 0 && obs_info.size() > 0) begin
      n_cmp++;
      if (obs_info[0] !== exp_info[0]) begin
        n_err++; $display("FAIL fifo_full_order: got %h want %h", obs_info[0], exp_info[0]);
      end
      void'(obs_info.pop_front()); void'(exp_info.pop_front());
    end
    exp_beats.delete(); obs_beats.delete(); exp_info.delete(); obs_info.delete();
  endtask

  task automatic test_back_to_back();
    int w;
    int want [4] = '{0, 0, 0, 1};
    logic [31:0] addr [4] = '{32'h0000_2000, 32'h0000_2100, 32'h0000_1FF8, 32'h0000_3000};
    @(negedge ACLK);
    m_AxREADY_i = 1'b1; info_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(4'(k + 1), addr[k], 8'd3, 3'd2, w);
      n_cmp++;
      if (w !== want[k]) begin
        n_err++; $display("FAIL back_to_back_wait b%0d: waited %0d want %0d", k, w, want[k]);
      end
    end
    wait_drain();
    n_cmp++;
    if (obs_beats.size() !== exp_beats.size()) begin
      n_err++; $display("FAIL back_to_back_count: beats %0d want %0d", obs_beats.size(), exp_beats.size());
    end
    while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
      n_cmp++;
      if (obs_beats[0] !== exp_beats[0]) begin
        n_err++; $display("FAIL back_to_back_beat: got %h want %h", obs_beats[0], exp_beats[0]);
      end
      void'(obs_beats.pop_front()); void'(exp_beats.pop_front());
    end
    while (exp_info.size() > 0 && obs_info.size() > 0) begin
      n_cmp++;
      if (obs_info[0] !== exp_info[0]) begin
        n_err++; $display("FAIL back_to_back_info: got %h want %h", obs_info[0], exp_info[0]);
      end
      void'(obs_info.pop_front()); void'(exp_info.pop_front());
    end
    exp_beats.delete(); obs_beats.delete(); exp_info.delete(); obs_info.delete();
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge ACLK);
    m_AxREADY_i = 1'b0; info_ready_i = 1'b0;
    send(4'hB, 32'h0000_0FF0, 8'd7, 3'd2, w);
    m_AxREADY_i = 1'b1;
    @(negedge ACLK);
    m_AxREADY_i = 1'b0;
    #1;
    n_cmp++;
    if ({m_AxVALID_o, m_split_first_o, m_AxADDR_o} !== {1'b1, 1'b0, 32'h0000_1000}) begin
      n_err++;
      $display("FAIL reset_mid_issue2: valid/sf/addr=%b/%b/%h want 1/0/00001000",
               m_AxVALID_o, m_split_first_o, m_AxADDR_o);
    end
    ARESET_i = 1'b1;
    #1;
    n_cmp++;
    if ({m_AxVALID_o, info_valid_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_mid_async: valid/info_valid=%b want 00", {m_AxVALID_o, info_valid_o});
    end
    // The second half and the info record are discarded by the reset.
    void'(exp_beats.pop_back());
    void'(exp_info.pop_back());
    @(negedge ACLK);
    ARESET_i = 1'b0;
    #1;
    n_cmp++;
    if (s_AxREADY_o !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_ready: s_AxREADY_o=%b want 1", s_AxREADY_o);
    end
    @(negedge ACLK);
    m_AxREADY_i = 1'b1; info_ready_i = 1'b1;
    send(4'hA, 32'h0000_0200, 8'd1, 3'd3, w);
    wait_drain();
    n_cmp++;
    if (obs_beats.size() !== exp_beats.size() || obs_info.size() !== exp_info.size()) begin
      n_err++;
      $display("FAIL reset_mid_count: beats %0d info %0d want %0d %0d",
               obs_beats.size(), obs_info.size(), exp_beats.size(), exp_info.size());
    end
    while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
      n_cmp++;
      if (obs_beats[0] !== exp_beats[0]) begin
        n_err++; $display("FAIL reset_mid_beat: got %h want %h", obs_beats[0], exp_beats[0]);
      end
      void'(obs_beats.pop_front()); void'(exp_beats.pop_front());
    end
    while (exp_info.size() > 0 && obs_info.size() > 0) begin
      n_cmp++;
      if (obs_info[0] !== exp_info[0]) begin
        n_err++; $display("FAIL reset_mid_info: got %h want %h", obs_info[0], exp_info[0]);
      end
      void'(obs_info.pop_front()); void'(exp_info.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_single("no_cross", 4'h1, 32'h0000_0100, 8'd7 - 8'd4, 3'd2);
    test_single("cross",    4'h2, 32'h0000_0FF0, 8'd7, 3'd2);
    test_single("boundary", 4'h3, 32'h0000_0FF0, 8'd3, 3'd2);
    test_backpressure();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
